fp32_mul_sequencer: RTL and testbench

- Multi-cycle controller for the single-precision (IEEE-754 binary32) multiplier path.
- Accepts operand pairs over a valid/ready handshake and unpacks them.
- Runs the 24x24 mantissa product on one shared shift-add adder over 24 cycles, then sequences normalization, round-to-nearest-even and packing.
- Sits between the issue logic and the result writeback; one operation in flight at a time.

---
 rtl/fp32_mul_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_fp32_mul_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_sequencer.sv
// Multi-cycle IEEE-754 binary32 multiplier controller: valid/ready operand intake,
// 24-step shift-add mantissa product, then normalize, round-to-nearest-even and pack.
module fp32_mul_sequencer #(
  parameter int MUL_ITERS = 24,
  parameter int BIAS      = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        busy
);

  localparam int CW = $clog2(MUL_ITERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITERS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic                in_ready_r, out_valid_r, busy_r;
  logic                sign_r;
  logic [7:0]          exp_a_r, exp_b_r;
  logic [23:0]         mcand_r;
  logic [47:0]         acc_r;
  logic [CW-1:0]       cnt_r;
  logic signed [9:0]   exp_r;
  logic [23:0]         mant_r;
  logic                guard_r, sticky_r;
  logic [31:0]         result_r;
  logic                ovf_r, unf_r;

  logic                accept_s, special_s;
  logic                nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
  logic [31:0]         special_res_s;
  logic [24:0]         add_s;
  logic signed [9:0]   exp_sum_s;
  logic                rnd_s;
  logic [24:0]         mant_inc_s;
  logic [23:0]         mant_fin_s;
  logic signed [9:0]   exp_fin_s;

  assign accept_s = in_valid && in_ready_r;
  assign nan_a_s  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
  assign nan_b_s  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
  assign inf_a_s  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
  assign inf_b_s  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
  // Denormals have exponent 0 and are deliberately folded into the zero class.
  assign zero_a_s = (op_a[30:23] == 8'd0);
  assign zero_b_s = (op_b[30:23] == 8'd0);
  assign special_s = nan_a_s || nan_b_s || inf_a_s || inf_b_s || zero_a_s || zero_b_s;

  // Special-operand result selection at accept time
  always_comb begin
    special_res_s = 32'd0;
    if (nan_a_s || nan_b_s || (inf_a_s && zero_b_s) || (inf_b_s && zero_a_s)) begin
      special_res_s = 32'h7FC0_0000;
    end else if (inf_a_s || inf_b_s) begin
      special_res_s = {op_a[31] ^ op_b[31], 8'hFF, 23'd0};
    end else begin
      special_res_s = {op_a[31] ^ op_b[31], 31'd0};
    end
  end

  // Shared adder, normalization exponent and rounding arithmetic
  always_comb begin
    add_s      = {1'b0, acc_r[47:24]} + (acc_r[0] ? {1'b0, mcand_r} : 25'd0);
    exp_sum_s  = {2'b00, exp_a_r} + {2'b00, exp_b_r} - 10'(BIAS);
    rnd_s      = guard_r && (sticky_r || mant_r[0]);
    mant_inc_s = {1'b0, mant_r} + {24'd0, rnd_s};
    if (mant_inc_s[24]) begin
      mant_fin_s = 24'h80_0000;
      exp_fin_s  = exp_r + 10'sd1;
    end else begin
      mant_fin_s = mant_inc_s[23:0];
      exp_fin_s  = exp_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = special_s ? DONE : MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_s = NORM;
        end else begin
          state_s = MUL;
        end
      end
      NORM:  state_s = ROUND;
      ROUND: state_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and handshake/status outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // Operand capture, shift-add multiply, normalize, round and result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r   <= 1'b0;
      exp_a_r  <= 8'd0;
      exp_b_r  <= 8'd0;
      mcand_r  <= 24'd0;
      acc_r    <= 48'd0;
      cnt_r    <= '0;
      exp_r    <= 10'sd0;
      mant_r   <= 24'd0;
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
      result_r <= 32'd0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sign_r  <= op_a[31] ^ op_b[31];
            exp_a_r <= op_a[30:23];
            exp_b_r <= op_b[30:23];
            mcand_r <= {(op_a[30:23] != 8'd0), op_a[22:0]};
            acc_r   <= {24'd0, (op_b[30:23] != 8'd0), op_b[22:0]};
            cnt_r   <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            result_r <= special_s ? special_res_s : 32'd0;
          end
        end
        MUL: begin
          acc_r <= {add_s, acc_r[23:1]};
          cnt_r <= cnt_r + CNT_ONE;
        end
        NORM: begin
          if (acc_r[47]) begin
            mant_r   <= acc_r[47:24];
            guard_r  <= acc_r[23];
            sticky_r <= |acc_r[22:0];
            exp_r    <= exp_sum_s + 10'sd1;
          end else begin
            mant_r   <= acc_r[46:23];
            guard_r  <= acc_r[22];
            sticky_r <= |acc_r[21:0];
            exp_r    <= exp_sum_s;
          end
        end
        ROUND: begin
          if (exp_fin_s >= 10'sd255) begin
            result_r <= {sign_r, 8'hFF, 23'd0};
            ovf_r    <= 1'b1;
          end else if (exp_fin_s <= 10'sd0) begin
            result_r <= {sign_r, 31'd0};
            unf_r    <= 1'b1;
          end else begin
            result_r <= {sign_r, exp_fin_s[7:0], mant_fin_s[22:0]};
          end
        end
        DONE: begin
          if (out_ready) begin
            result_r <= 32'd0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
          end
        end
        default: begin
          result_r <= 32'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign result    = result_r;
  assign overflow  = ovf_r;
  assign underflow = unf_r;

endmodule

// File: tb/tb_fp32_mul_sequencer.sv
// Directed, table-driven bench for fp32_mul_sequencer plus hand-written
// backpressure and mid-operation reset sequences.
module tb_fp32_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, underflow, busy;

  int checks = 0;
  int errors = 0;

  fp32_mul_sequencer #(.MUL_ITERS(24), .BIAS(127)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ov;
    logic        un;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the block idle; returns at a negedge after the result was taken.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] r,
                       output logic ov, output logic un, output int busy_lo);
    in_valid = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    lat = 1; busy_lo = 0;
    while (!out_valid && lat < 100) begin
      if (!busy) busy_lo++;
      @(negedge clk);
      lat++;
    end
    r = result; ov = overflow; un = underflow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat, busy_lo, seen;
    logic [31:0] r, held;
    logic        ov, un;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 27};
    vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, 27};
    vecs[2]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0, 27};
    vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 27};
    vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 27};
    vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[6]  = '{32'h80000000, 32'h40490FDB, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1};
    vecs[8]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0, 27};
    vecs[9]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0, 1'b0, 27};
    vecs[10] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[11] = '{32'hC0000000, 32'h3F800000, 32'hC0000000, 1'b0, 1'b0, 27};
    vecs[12] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset flags", {30'd0, overflow, underflow}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      do_op(vecs[i].a, vecs[i].b, lat, r, ov, un, busy_lo);
      chk($sformatf("v%0d result", i), r, vecs[i].res);
      chk($sformatf("v%0d overflow", i), {31'd0, ov}, {31'd0, vecs[i].ov});
      chk($sformatf("v%0d underflow", i), {31'd0, un}, {31'd0, vecs[i].un});
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d busy gaps", i), busy_lo, 32'd0);
      chk($sformatf("v%0d out_valid drop", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d flags cleared", i), {30'd0, overflow, underflow}, 32'd0);
    end

    // Backpressure: hold a result in DONE with a pending request waiting
    in_valid = 1'b1; op_a = 32'h7F000000; op_b = 32'h7F000000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency", lat, 32'd27);
    held = result;
    chk("bp result", held, 32'h7F800000);
    in_valid = 1'b1; op_a = 32'h40000000; op_b = 32'h40000000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d result", k), result, 32'h7F800000);
      chk($sformatf("bp%0d overflow", k), {31'd0, overflow}, 32'd1);
      chk($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp idle out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp idle in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp idle busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; op_a = 32'd0; op_b = 32'd0;
    chk("bp pending accepted", {31'd0, busy}, 32'd1);
    chk("bp pending in_ready", {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp pending latency", lat, 32'd27);
    chk("bp pending result", result, 32'h40800000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the 10th MUL cycle aborts the operation
    in_valid = 1'b1; op_a = 32'h3FC00000; op_b = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort busy before reset", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("abort no result", seen, 32'd0);
    do_op(32'h40000000, 32'h40000000, lat, r, ov, un, busy_lo);
    chk("post-abort result", r, 32'h40800000);
    chk("post-abort latency", lat, 32'd27);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
